// File: rtl/bulk_requester.sv
// Bulk-port initiator: turns host burst commands into one-word-per-grant requests,
// feeds write data on a grant-relative latency and captures read data the same way.
module bulk_requester #(
  parameter int WFIFO_AW    = 4,
  parameter int WR_DATA_LAT = 2,
  parameter int RD_DATA_LAT = 6
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_WE,
  input  logic [25:0] CMD_ADDR,
  input  logic [7:0]  CMD_LEN,
  input  logic        WDATA_VALID,
  input  logic [31:0] WDATA,
  output logic        WDATA_READY,
  output logic        RDATA_VALID,
  output logic [31:0] RDATA,
  output logic        DONE,
  output logic [25:0] ADDRESS_BULK,
  output logic        WE_BULK,
  output logic        REQUEST_ACCESS_BULK,
  input  logic        GRANT_ACCESS_BULK,
  output logic [31:0] DATA_W,
  input  logic [31:0] DATA_R
);
  localparam int WP    = WR_DATA_LAT - 1;
  localparam int DEPTH = 1 << WFIFO_AW;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [25:0]            addr_q, addr_d;
  logic                   we_q, we_d;
  logic [8:0]             rem_q, rem_d;
  logic                   req_q, req_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [WP-1:0]          wr_pipe_q, wr_pipe_d;
  logic [RD_DATA_LAT-1:0] rd_pipe_q, rd_pipe_d;
  logic [WFIFO_AW:0]      cnt_q, cnt_d, sched_q, sched_d;
  logic [WFIFO_AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [31:0]            data_w_q, data_w_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   rdata_vld_q, rdata_vld_d;
  logic [31:0]            fifo_mem [DEPTH];

  logic grant_ok, grant_wr, push, wr_tap, pop, rd_tap;

  always_comb begin
    grant_ok = GRANT_ACCESS_BULK && req_q;
    grant_wr = grant_ok && we_q;
    push     = WDATA_VALID && !cnt_q[WFIFO_AW];
    wr_tap   = wr_pipe_q[WP-1];
    pop      = wr_tap && (cnt_q != '0);
    rd_tap   = rd_pipe_q[RD_DATA_LAT-1];

    wr_pipe_d[0] = grant_wr;
    for (int i = 1; i < WP; i++) wr_pipe_d[i] = wr_pipe_q[i-1];
    rd_pipe_d[0] = grant_ok && !we_q;
    for (int i = 1; i < RD_DATA_LAT; i++) rd_pipe_d[i] = rd_pipe_q[i-1];

    cnt_d   = cnt_q + (WFIFO_AW+1)'(push) - (WFIFO_AW+1)'(pop);
    // Grants whose pop has not happened yet; the FIFO must cover them before asking again.
    sched_d = sched_q + (WFIFO_AW+1)'(grant_wr) - (WFIFO_AW+1)'(wr_tap);
    wptr_d  = push ? wptr_q + WFIFO_AW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + WFIFO_AW'(1) : rptr_q;

    data_w_d    = pop ? fifo_mem[rptr_q] : data_w_q;
    rdata_d     = rd_tap ? DATA_R : rdata_q;
    rdata_vld_d = rd_tap;
    err_d       = err_q | (GRANT_ACCESS_BULK && !req_q);

    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (CMD_VALID) begin
          addr_d  = CMD_ADDR;
          we_d    = CMD_WE;
          rem_d   = (CMD_LEN == 8'd0) ? 9'd256 : {1'b0, CMD_LEN};
          state_d = RUN;
        end
      end
      RUN: begin
        if (grant_ok) begin
          addr_d = addr_q + 26'd1;
          rem_d  = rem_q - 9'd1;
          if (rem_d == 9'd0) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (wr_pipe_q == '0 && rd_pipe_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    req_d       = (state_d == RUN) && (rem_d != 9'd0) && (!we_d || (cnt_d > sched_d));
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      rem_q       <= '0;
      req_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      wr_pipe_q   <= '0;
      rd_pipe_q   <= '0;
      cnt_q       <= '0;
      sched_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      data_w_q    <= '0;
      rdata_q     <= '0;
      rdata_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      rem_q       <= rem_d;
      req_q       <= req_d;
      cmd_ready_q <= cmd_ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
      wr_pipe_q   <= wr_pipe_d;
      rd_pipe_q   <= rd_pipe_d;
      cnt_q       <= cnt_d;
      sched_q     <= sched_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      data_w_q    <= data_w_d;
      rdata_q     <= rdata_d;
      rdata_vld_q <= rdata_vld_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wptr_q] <= WDATA;
  end

  assign CMD_READY           = cmd_ready_q;
  assign WDATA_READY         = !cnt_q[WFIFO_AW];
  assign RDATA_VALID         = rdata_vld_q;
  assign RDATA               = rdata_q;
  assign DONE                = done_q;
  assign ADDRESS_BULK        = addr_q;
  assign WE_BULK             = we_q;
  assign REQUEST_ACCESS_BULK = req_q;
  assign DATA_W              = data_w_q;
endmodule

// File: tb/tb_bulk_requester.sv
// Bench for bulk_requester: table of bursts plus hand-written starvation, reset and spurious-grant sequences.
module tb_bulk_requester;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CMD_VALID = 1'b0, CMD_READY, CMD_WE = 1'b0;
  logic [25:0] CMD_ADDR = '0;
  logic [7:0]  CMD_LEN = '0;
  logic        WDATA_VALID = 1'b0, WDATA_READY;
  logic [31:0] WDATA = '0;
  logic        RDATA_VALID, DONE, WE_BULK, REQUEST_ACCESS_BULK;
  logic [31:0] RDATA, DATA_W;
  logic [25:0] ADDRESS_BULK;
  logic        GRANT_ACCESS_BULK = 1'b0;
  logic [31:0] DATA_R = '0;

  bulk_requester #(.WFIFO_AW(4), .WR_DATA_LAT(2), .RD_DATA_LAT(6)) dut (
    .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WE(CMD_WE),
    .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN), .WDATA_VALID(WDATA_VALID), .WDATA(WDATA),
    .WDATA_READY(WDATA_READY), .RDATA_VALID(RDATA_VALID), .RDATA(RDATA), .DONE(DONE),
    .ADDRESS_BULK(ADDRESS_BULK), .WE_BULK(WE_BULK), .REQUEST_ACCESS_BULK(REQUEST_ACCESS_BULK),
    .GRANT_ACCESS_BULK(GRANT_ACCESS_BULK), .DATA_W(DATA_W), .DATA_R(DATA_R)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  typedef struct { int due; logic [31:0] val; } ev_t;
  ev_t         wq[$], rq[$], dq[$];
  logic [31:0] fifo_m[$];
  logic [31:0] dw_exp = '0;
  bit          mon_en = 1'b0;
  int          done_cnt = 0;

  typedef struct {
    logic        we;
    logic [25:0] addr;
    logic [7:0]  len;
    int          gap;
    int          npush;
    logic [25:0] exp_end;
    int          words;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard side: every cycle DATA_W and RDATA_VALID/RDATA are compared with the expectations queued at grant time.
  always @(posedge CLK) begin
    #1;
    if (mon_en) begin
      if (wq.size() != 0 && wq[0].due == cyc) begin
        dw_exp = wq[0].val;
        void'(wq.pop_front());
      end
      chk("data_w", DATA_W, dw_exp);
      if (rq.size() != 0 && rq[0].due == cyc) begin
        chk("rdata_valid", 32'(RDATA_VALID), 32'd1);
        chk("rdata", RDATA, rq[0].val);
        void'(rq.pop_front());
      end else begin
        chk("rdata_valid", 32'(RDATA_VALID), 32'd0);
      end
      if (DONE) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    if (dq.size() != 0 && dq[0].due == cyc) begin
      DATA_R = dq[0].val;
      void'(dq.pop_front());
    end else begin
      DATA_R = $urandom;
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    mon_en = 1'b0;
    wq.delete(); rq.delete(); dq.delete(); fifo_m.delete();
    tick();
    RST = 1'b0;
    dw_exp = '0;
    mon_en = 1'b1;
  endtask

  task automatic push_word(input logic [31:0] w);
    chk("wdata_ready", 32'(WDATA_READY), 32'(fifo_m.size() < 16));
    WDATA_VALID = 1'b1;
    WDATA = w;
    if (fifo_m.size() < 16) fifo_m.push_back(w);
    tick();
    WDATA_VALID = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [25:0] a, input logic [7:0] len);
    chk("cmd_ready_idle", 32'(CMD_READY), 32'd1);
    CMD_VALID = 1'b1; CMD_WE = we; CMD_ADDR = a; CMD_LEN = len;
    tick();
    CMD_VALID = 1'b0;
    chk("cmd_ready_busy", 32'(CMD_READY), 32'd0);
  endtask

  task automatic do_grant(input logic [25:0] a, input logic we, input int idx);
    logic [31:0] w;
    chk("addr_at_grant", 32'(ADDRESS_BULK), 32'(a));
    chk("we_at_grant", 32'(WE_BULK), 32'(we));
    GRANT_ACCESS_BULK = 1'b1;
    if (we) begin
      w = (fifo_m.size() != 0) ? fifo_m.pop_front() : 32'hDEADBEEF;
      wq.push_back('{cyc + 2, w});
    end else begin
      dq.push_back('{cyc + 6, 32'(idx)});
      rq.push_back('{cyc + 7, 32'(idx)});
    end
    tick();
    GRANT_ACCESS_BULK = 1'b0;
  endtask

  task automatic run_grants(input logic we, input logic [25:0] a0, input int n, input int gap, output int gl);
    int k = 0;
    int since = gap;
    int budget = 4 * n * gap + 40;
    gl = cyc;
    while (k < n && budget > 0) begin
      if (REQUEST_ACCESS_BULK && since >= gap) begin
        gl = cyc;
        do_grant(a0 + 26'(k), we, k);
        k++;
        since = 1;
      end else begin
        tick();
        since++;
      end
      budget--;
    end
    chk("grant_count", 32'(k), 32'(n));
  endtask

  task automatic wait_req();
    int b = 0;
    while (!REQUEST_ACCESS_BULK && b < 20) begin tick(); b++; end
    chk("req_wait", 32'(REQUEST_ACCESS_BULK), 32'd1);
  endtask

  task automatic wait_done(input int exp_cyc, input logic [25:0] exp_end);
    int b = 0;
    while (!DONE && b < 40) begin tick(); b++; end
    chk("done_cycle", 32'(cyc), 32'(exp_cyc));
    chk("done_addr", 32'(ADDRESS_BULK), 32'(exp_end));
    chk("done_cmd_ready", 32'(CMD_READY), 32'd1);
    chk("done_req", 32'(REQUEST_ACCESS_BULK), 32'd0);
    tick();
    chk("done_pulse", 32'(DONE), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int gl, d0;
    logic [25:0] a;

    vecs[0] = '{1'b1, 26'h0000FFE, 8'd4,  3, 4,  26'h0001002, 4};
    vecs[1] = '{1'b0, 26'h0123400, 8'd0,  2, 0,  26'h0123500, 256};
    vecs[2] = '{1'b1, 26'h3FFFFFE, 8'd2,  2, 2,  26'h0000000, 2};
    vecs[3] = '{1'b0, 26'h3FFFFFC, 8'd4,  4, 0,  26'h0000000, 4};
    vecs[4] = '{1'b1, 26'h1234567, 8'd16, 2, 17, 26'h1234577, 16};

    tick();
    do_reset();
    chk("rst_cmd_ready", 32'(CMD_READY), 32'd1);
    chk("rst_wdata_ready", 32'(WDATA_READY), 32'd1);
    chk("rst_req", 32'(REQUEST_ACCESS_BULK), 32'd0);
    chk("rst_addr", 32'(ADDRESS_BULK), 32'd0);
    chk("rst_we", 32'(WE_BULK), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_rvalid", 32'(RDATA_VALID), 32'd0);
    chk("rst_rdata", RDATA, 32'd0);
    chk("rst_dataw", DATA_W, 32'd0);
    chk("rst_err", 32'(dut.err_q), 32'd0);

    // Spurious grant while idle.
    GRANT_ACCESS_BULK = 1'b1;
    tick();
    GRANT_ACCESS_BULK = 1'b0;
    tick();
    chk("spur_addr", 32'(ADDRESS_BULK), 32'd0);
    chk("spur_cmd_ready", 32'(CMD_READY), 32'd1);
    chk("spur_req", 32'(REQUEST_ACCESS_BULK), 32'd0);
    chk("spur_err", 32'(dut.err_q), 32'd1);
    chk("spur_done", 32'(done_cnt), 32'd0);

    for (int t = 0; t < 5; t++) begin
      d0 = done_cnt;
      for (int i = 0; i < vecs[t].npush; i++) push_word(32'hA0 + 32'(i) + (32'(t) << 24));
      issue(vecs[t].we, vecs[t].addr, vecs[t].len);
      run_grants(vecs[t].we, vecs[t].addr, vecs[t].words, vecs[t].gap, gl);
      chk("req_after_last", 32'(REQUEST_ACCESS_BULK), 32'd0);
      chk("cmd_ready_drain", 32'(CMD_READY), 32'd0);
      wait_done(gl + (vecs[t].we ? 3 : 8), vecs[t].exp_end);
      chk("done_count", 32'(done_cnt - d0), 32'd1);
    end

    // Write burst starved by an almost-empty FIFO.
    d0 = done_cnt;
    a = 26'h0ABCDE0;
    push_word(32'h5A5A0001);
    issue(1'b1, a, 8'd3);
    wait_req();
    do_grant(a, 1'b1, 0);
    chk("req_starved", 32'(REQUEST_ACCESS_BULK), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("req_still_starved", 32'(REQUEST_ACCESS_BULK), 32'd0);
    end
    push_word(32'h5A5A0002);
    chk("req_rearm", 32'(REQUEST_ACCESS_BULK), 32'd1);
    do_grant(a + 26'd1, 1'b1, 1);
    chk("req_starved2", 32'(REQUEST_ACCESS_BULK), 32'd0);
    push_word(32'h5A5A0003);
    chk("req_rearm2", 32'(REQUEST_ACCESS_BULK), 32'd1);
    gl = cyc;
    do_grant(a + 26'd2, 1'b1, 2);
    chk("req_after_last_s", 32'(REQUEST_ACCESS_BULK), 32'd0);
    wait_done(gl + 3, a + 26'd3);
    chk("done_count_s", 32'(done_cnt - d0), 32'd1);

    // Reset two cycles after the first grant of a read burst.
    d0 = done_cnt;
    issue(1'b0, 26'h0000100, 8'd8);
    wait_req();
    do_grant(26'h0000100, 1'b0, 0);
    tick();
    do_reset();
    chk("mrst_req", 32'(REQUEST_ACCESS_BULK), 32'd0);
    chk("mrst_cmd_ready", 32'(CMD_READY), 32'd1);
    chk("mrst_addr", 32'(ADDRESS_BULK), 32'd0);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("mrst_req_low", 32'(REQUEST_ACCESS_BULK), 32'd0);
    end
    chk("mrst_no_done", 32'(done_cnt - d0), 32'd0);

    tick();
    chk("wq_drained", 32'(wq.size()), 32'd0);
    chk("rq_drained", 32'(rq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bulk_requester.md
Name: bulk_requester

Overview:
Initiator for the SDRAM controller's bulk port. It accepts burst commands from a host, with a start word address, a direction and a length, and drives REQUEST_ACCESS_BULK, ADDRESS_BULK and WE_BULK, one 32-bit word per GRANT_ACCESS_BULK. It supplies write data to the output datapath on a fixed grant-relative latency and captures read data the same way. Sits between DMA/host logic and the command issuer plus output datapath.

Parameters:
WFIFO_AW, 4, log2 depth of the internal write-data FIFO (16 words).
WR_DATA_LAT, 2, cycles from the GRANT_ACCESS_BULK high cycle to the cycle the granted word must first appear on DATA_W.
RD_DATA_LAT, 6, cycles from the GRANT_ACCESS_BULK high cycle to the cycle DATA_R holds that word's read data.

Ports:
CLK  in  1  single clock (controller clock).
RST  in  1  synchronous reset, active-high.
CMD_VALID  in  1  host command valid.
CMD_READY  out  1  high only in IDLE.
CMD_WE  in  1  1 = write burst, 0 = read burst.
CMD_ADDR  in  26  start word address: row[25:14], bank[13:12], column word[11:0].
CMD_LEN  in  8  word count; 0 encodes 256.
WDATA_VALID  in  1  host write-data push.
WDATA  in  32  write word.
WDATA_READY  out  1  FIFO not full.
RDATA_VALID  out  1  one-cycle strobe per read word.
RDATA  out  32  read word.
DONE  out  1  one-cycle pulse when a burst fully completes.
ADDRESS_BULK  out  26  to controller.
WE_BULK  out  1  to controller.
REQUEST_ACCESS_BULK  out  1  to controller.
GRANT_ACCESS_BULK  in  1  from controller; one word accepted.
DATA_W  out  32  to output datapath.
DATA_R  in  32  from output datapath.

Behaviour:
- Reset: all outputs 0, except CMD_READY=1 and WDATA_READY=1. FIFO flushed. State IDLE. Grant pipelines cleared. Reset mid-burst abandons the burst, drops the request in the next cycle, and generates no DONE.
- States: IDLE, RUN, DRAIN.
- IDLE: on CMD_VALID, latch address, WE and remaining = CMD_LEN (0 → 256, 9-bit counter), then go to RUN. Request does not rise in the same cycle.
- RUN, request rule: REQUEST_ACCESS_BULK is registered. It is high when remaining≠0, and, for writes, when FIFO count > pops already scheduled.
- RUN, address/direction rule: ADDRESS_BULK and WE_BULK are constant while the request is high.
- Per grant (GRANT high): in the next cycle, ADDRESS_BULK += 1 (26-bit wrap, carrying into bank/row freely) and remaining -= 1. If remaining becomes 0, the request is low in that next cycle.
- Grant spacing: the controller never grants in consecutive cycles. If it does, each grant still counts once.
- Ignored grants: GRANT while the request is low, or in IDLE, is ignored; count it in a sticky internal error flag.
- RUN → DRAIN when remaining reaches 0.
- Write path: a shift register of grants delays each one by WR_DATA_LAT−1. At the tap, the FIFO head is popped into a DATA_W register, so DATA_W changes exactly WR_DATA_LAT cycles after the grant and holds until the next pop.
- FIFO: push when WDATA_VALID && WDATA_READY. Simultaneous push and pop are allowed. Push while full is dropped.
- Read path: grants are delayed RD_DATA_LAT cycles. At the tap, RDATA <= DATA_R and RDATA_VALID=1 for one cycle. There is no backpressure.
- DRAIN: wait until both grant pipelines are empty, then DONE=1 for one cycle and return to IDLE. CMD_READY rises in that same cycle.
- A new command is not accepted before DONE.

Test Plan:
- Write, CMD_ADDR=0x0000FFE, LEN=4, FIFO preloaded with A0..A3; grants every 3rd cycle → ADDRESS_BULK sequence 0xFFE, 0xFFF, 0x1000, 0x1001. DATA_W shows A0..A3, each 2 cycles after its grant. Request low the cycle after the 4th grant. DONE 1 cycle after the last pop.
- Read, LEN=0 (256 words), grants every other cycle; bench drives DATA_R = grant index 6 cycles after each grant → 256 RDATA_VALID pulses, RDATA 0..255 in order, ADDRESS_BULK ends at start+256, one DONE.
- Write, LEN=3, FIFO holding only 1 word → request drops after the first grant. Pushing the second word re-raises the request the next cycle. No underflow occurs.
- ADDRESS_BULK=0x3FFFFFF at the last word boundary → wraps to 0x0000000.
- RST asserted two cycles after the first grant of a read LEN=8 → next cycle: request 0, CMD_READY 1, no RDATA_VALID and no DONE afterwards.
- Spurious GRANT in IDLE → no address change, error flag set, state unchanged.
